hex_debug_pager: RTL and testbench



---
 rtl/hex_debug_pager.sv | 175 +++++++++++++++++
 tb/tb_hex_debug_pager.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_debug_pager.sv
// Seven-segment pager over WORDS debug words with debounced next/prev buttons and auto-scroll.
// Define HEX_DBG_FREEZE_EN to add the freeze port and the debug-bus snapshot.

module hex_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  // Active-low segments, bit 0 = a ... bit 6 = g
  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b0000011;
      4'hc: seg = 7'b1000110;
      4'hd: seg = 7'b0100001;
      4'he: seg = 7'b0000110;
      4'hf: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module hex_dbg_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press_c
);
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

  logic          s1, s2, deb, deb_d, armed;
  logic [1:0]    settle;
  logic [DW-1:0] dc;

  // armed only after the button is seen released once the synchroniser has refilled,
  // so a button held across reset never produces a press
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      deb    <= 1'b0;
      deb_d  <= 1'b0;
      armed  <= 1'b0;
      settle <= '0;
      dc     <= '0;
    end else begin
      s1     <= btn;
      s2     <= s1;
      deb_d  <= deb;
      settle <= {settle[0], 1'b1};
      if (settle[1] && !s2) armed <= 1'b1;
      if (s2 != deb) begin
        if (dc == DW'(DEB_CYCLES - 1)) begin
          deb <= s2;
          dc  <= '0;
        end else begin
          dc <= dc + DW'(1);
        end
      end else begin
        dc <= '0;
      end
    end
  end

  assign press_c = deb & ~deb_d & armed;
endmodule

module hex_debug_pager #(
  parameter  int unsigned WORDS         = 4,
  parameter  int unsigned DIGITS        = 6,
  parameter  int unsigned DEB_CYCLES    = 50000,
  parameter  int unsigned SCROLL_CYCLES = 50000000,
  localparam int unsigned PW            = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [32*WORDS-1:0]   debug,
  input  logic                  btn_next,
  input  logic                  btn_prev,
  input  logic                  auto_en,
`ifdef HEX_DBG_FREEZE_EN
  input  logic                  freeze,
`endif
  output logic [7*DIGITS-1:0]   hex,
  output logic [PW-1:0]         page
);
  localparam int unsigned SW = $clog2(SCROLL_CYCLES);

  logic                next_c, prev_c, tick_c, fwd_c;
  logic [SW-1:0]       sc;
  logic [31:0]         disp;
  logic [32*WORDS-1:0] src_c;
  logic [31:0]         words [WORDS];

  hex_dbg_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk(clk), .reset_n(reset_n), .btn(btn_next), .press_c(next_c)
  );
  hex_dbg_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
    .clk(clk), .reset_n(reset_n), .btn(btn_prev), .press_c(prev_c)
  );

  // A timer tick only counts when no button pulse arrives in the same cycle
  assign tick_c = auto_en && (sc == SW'(SCROLL_CYCLES - 1));
  assign fwd_c  = next_c | (tick_c & ~prev_c);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sc <= '0;
    end else if (!auto_en || next_c || prev_c || tick_c) begin
      sc <= '0;
    end else begin
      sc <= sc + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      page <= '0;
    end else if (fwd_c && !prev_c) begin
      page <= (page == PW'(WORDS - 1)) ? '0 : page + PW'(1);
    end else if (prev_c && !fwd_c) begin
      page <= (page == '0) ? PW'(WORDS - 1) : page - PW'(1);
    end
  end

`ifdef HEX_DBG_FREEZE_EN
  logic [2:0]          fz;
  logic [32*WORDS-1:0] snap;

  // fz[2] rises on the same edge the snapshot is captured, so src never shows a stale snapshot
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fz   <= '0;
      snap <= '0;
    end else begin
      fz <= {fz[1:0], freeze};
      if (fz[1] && !fz[2]) snap <= debug;
    end
  end

  assign src_c = fz[2] ? snap : debug;
`else
  assign src_c = debug;
`endif

  always_comb begin
    for (int i = 0; i < int'(WORDS); i++) words[i] = src_c[32*i +: 32];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) disp <= '0;
    else          disp <= words[page];
  end

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_dig
    hex_decoder u_dec (.digit(disp[4*k +: 4]), .seg(hex[7*k +: 7]));
  end

  if (DIGITS < 8) begin : g_spare
    logic unused_digits;
    assign unused_digits = ^disp[31:4*DIGITS];
  end
endmodule

// File: tb/tb_hex_debug_pager.sv
// Randomised and directed bench for hex_debug_pager against a page/segment reference model.
// Exercises the freeze snapshot only when HEX_DBG_FREEZE_EN is defined.

module tb_hex_debug_pager;
  localparam int WORDS  = 4;
  localparam int DIGITS = 6;
  localparam int DEB    = 4;
  localparam int SCROLL = 10;
  localparam int PW     = 2;

  logic                  clk = 1'b0;
  logic                  reset_n, btn_next, btn_prev, auto_en;
  logic [32*WORDS-1:0]   debug;
  logic [7*DIGITS-1:0]   hex;
  logic [PW-1:0]         page;
`ifdef HEX_DBG_FREEZE_EN
  logic                  freeze;
`endif

  int                    vectors = 0;
  int                    miscompares = 0;
  int                    page_m = 0;
  logic                  frozen_m = 1'b0;
  logic [32*WORDS-1:0]   snap_m = '0;
  logic [6:0]            seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

  always #5 clk = ~clk;

  hex_debug_pager #(
    .WORDS(WORDS), .DIGITS(DIGITS), .DEB_CYCLES(DEB), .SCROLL_CYCLES(SCROLL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .debug(debug),
    .btn_next(btn_next),
    .btn_prev(btn_prev),
    .auto_en(auto_en),
`ifdef HEX_DBG_FREEZE_EN
    .freeze(freeze),
`endif
    .hex(hex),
    .page(page)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7*DIGITS-1:0] exp_hex(input logic [4*DIGITS-1:0] w);
    logic [7*DIGITS-1:0] r;
    for (int k = 0; k < DIGITS; k++) r[7*k +: 7] = seg_tab[w[4*k +: 4]];
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_for(input int p);
    logic [32*WORDS-1:0] s;
    s = frozen_m ? snap_m : debug;
    return exp_hex(s[32*p +: 4*DIGITS]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_view(input string tag);
    check({tag, "_page"}, 64'(page), 64'(page_m));
    check({tag, "_hex"}, 64'(hex), 64'(exp_for(page_m)));
  endtask

  // op: 0 none, 1 next, 2 prev, 3 both; page must step exactly at edge DEB+3 after the raise
  task automatic press(input int op, input int hold, input int rel);
    int old_p, new_p;
    old_p = page_m;
    case (op)
      1:       new_p = (page_m + 1) % WORDS;
      2:       new_p = (page_m + WORDS - 1) % WORDS;
      default: new_p = page_m;
    endcase
    btn_next = (op == 1 || op == 3);
    btn_prev = (op == 2 || op == 3);
    for (int e = 1; e <= hold; e++) begin
      tick();
      if (e == DEB + 2) check("pre_step", 64'(page), 64'(old_p));
      if (e == DEB + 3) check("step", 64'(page), 64'(new_p));
    end
    btn_next = 1'b0;
    btn_prev = 1'b0;
    page_m = new_p;
    ticks(rel);
    check_view("after_press");
  endtask

  initial begin
    reset_n  = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    auto_en  = 1'b0;
`ifdef HEX_DBG_FREEZE_EN
    freeze   = 1'b0;
`endif
    debug = {32'h00DDDDDD, 32'h00CCCCCC, 32'h00BBBBBB, 32'h00AAAAAA};
    ticks(3);
    check("reset_page", 64'(page), 64'(0));
    check("reset_hex", 64'(hex), 64'(exp_hex('0)));
    reset_n = 1'b1;
    ticks(3);
    check_view("post_reset");

    // reset in the middle of a held press, then keep holding: no step
    btn_next = 1'b1;
    ticks(4);
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    ticks(20);
    check("reset_mid_press", 64'(page), 64'(0));
    btn_next = 1'b0;
    ticks(12);
    check_view("reset_release");

    for (int i = 0; i < 4; i++) press(1, 20, 12);

    // short bounces on prev are rejected, the later hold counts
    for (int i = 0; i < 3; i++) begin
      btn_prev = 1'b1;
      tick();
      btn_prev = 1'b0;
      tick();
    end
    ticks(8);
    check_view("bounce");
    press(2, 20, 12);
    check("prev_wrap_hex", 64'(hex), 64'(exp_hex(24'hDDDDDD)));

    press(3, 20, 12);
    press(1, 20, 12);

    // auto-scroll from page 0
    auto_en = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 9)  check("auto_e9", 64'(page), 64'(0));
      if (e == 10) check("auto_e10", 64'(page), 64'(1));
      if (e == 19) check("auto_e19", 64'(page), 64'(1));
      if (e == 20) check("auto_e20", 64'(page), 64'(2));
    end
    auto_en = 1'b0;
    page_m = 2;
    ticks(2);
    press(1, 20, 12);
    press(1, 20, 12);

    // prev press landing at edge 15 restarts the scroll period
    auto_en = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      tick();
      if (e == 10) check("auto_b_e10", 64'(page), 64'(1));
      if (e == 14) check("auto_b_e14", 64'(page), 64'(1));
      if (e == 15) check("auto_b_prev", 64'(page), 64'(0));
      if (e == 24) check("auto_b_e24", 64'(page), 64'(0));
      if (e == 25) check("auto_b_e25", 64'(page), 64'(1));
      if (e == 8)  btn_prev = 1'b1;
      if (e == 20) btn_prev = 1'b0;
    end
    auto_en = 1'b0;
    page_m = 1;
    ticks(10);
    check_view("auto_b_done");

`ifdef HEX_DBG_FREEZE_EN
    press(2, 20, 12);
    freeze = 1'b1;
    ticks(5);
    snap_m = debug;
    frozen_m = 1'b1;
    debug[31:0]  = 32'h00123456;
    debug[63:32] = $urandom;
    ticks(3);
    check("frozen_hex", 64'(hex), 64'(exp_hex(24'hAAAAAA)));
    press(1, 20, 12);
    press(2, 20, 12);
    freeze = 1'b0;
    frozen_m = 1'b0;
    ticks(4);
    check("unfrozen_hex", 64'(hex), 64'(exp_hex(24'h123456)));
`endif

    // random paging with random live data
    for (int it = 0; it < 16; it++) begin
      for (int w = 0; w < WORDS; w++) debug[32*w +: 32] = $urandom;
      tick();
      check("live_latency", 64'(hex), 64'(exp_for(page_m)));
      press(int'($urandom_range(0, 3)), int'($urandom_range(8, 20)), int'($urandom_range(8, 14)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
